// File: rtl/aryth_pkg.sv
// aryth_pkg: shared states, opcodes, status codes and opcode legality check for the ARYTH sequencer
package aryth_pkg;
  localparam int NUM_OPS = 6;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_OUT_LO = 3'd5;
  localparam logic [2:0] S_OUT_HI = 3'd6;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ILLOP = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  function automatic logic op_legal(input logic [2:0] op, input int n);
    return 32'(op) < n;
  endfunction
endpackage

// File: rtl/aryth_timeout_ctr.sv
// aryth_timeout_ctr: cycle counter that flags expiry once it reaches TIMEOUT-1
module aryth_timeout_ctr #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  import aryth_pkg::*;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // clear has priority over counting; neither asserted means hold
  always_comb cnt_d = clear ? '0 : enable ? cnt_q + CW'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/aryth_op_sequencer.sv
// aryth_op_sequencer: byte-stream command sequencer issuing one op to the ARYTH datapath and returning its result
module aryth_op_sequencer #(
  parameter int DATA_W  = 8,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 32,
  parameter int NUM_OPS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_stb,
  output logic              in_rdy,
  output logic              alu_start,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [RES_W-1:0]  alu_result,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ack,
  output logic              busy,
  output logic [1:0]        err
);
  import aryth_pkg::*;
  logic [2:0] state_q, state_d, op_q, op_d;
  logic un_q, un_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [RES_W-1:0] res_q, res_d;
  logic [1:0] err_q, err_d;
  logic acc, legal, expired, in_flight, unused_cmd;
  assign in_rdy = state_q == S_IDLE || state_q == S_LOAD_A || state_q == S_LOAD_B;
  assign acc = in_stb & in_rdy & ena;
  assign legal = op_legal(in_data[2:0], NUM_OPS);
  assign unused_cmd = ^in_data[DATA_W-2:3];
  assign in_flight = state_q == S_ISSUE || state_q == S_WAIT;
  assign alu_start = ena && state_q == S_ISSUE;
  assign alu_op = op_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign out_valid = state_q == S_OUT_LO || state_q == S_OUT_HI;
  assign out_data = state_q == S_OUT_LO ? res_q[DATA_W-1:0] : state_q == S_OUT_HI ? res_q[RES_W-1:DATA_W] : '0;
  assign busy = state_q != S_IDLE;
  assign err = err_q;
  aryth_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk),
    .rst(rst),
    .clear(ena & ~in_flight),
    .enable(ena & in_flight),
    .expired(expired)
  );
  // next state, operand capture and status; ena low freezes everything
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    un_d = un_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    err_d = err_q;
    if (ena) begin
      case (state_q)
        S_IDLE: if (acc) begin
          err_d = legal ? ERR_OK : ERR_ILLOP;
          state_d = legal ? S_LOAD_A : S_IDLE;
          op_d = legal ? in_data[2:0] : op_q;
          un_d = legal ? in_data[DATA_W-1] : un_q;
        end
        S_LOAD_A: if (acc) begin
          a_d = in_data;
          b_d = un_q ? '0 : b_q;
          state_d = un_q ? S_ISSUE : S_LOAD_B;
        end
        S_LOAD_B: if (acc) begin
          b_d = in_data;
          state_d = S_ISSUE;
        end
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          res_d = alu_done ? alu_result : res_q;
          err_d = (!alu_done && expired) ? ERR_TMO : err_q;
          state_d = alu_done ? S_OUT_LO : expired ? S_IDLE : S_WAIT;
        end
        S_OUT_LO: state_d = out_ack ? S_OUT_HI : S_OUT_LO;
        S_OUT_HI: state_d = out_ack ? S_IDLE : S_OUT_HI;
        default: state_d = S_IDLE;
      endcase
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      op_q <= '0;
      un_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      err_q <= ERR_OK;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      un_q <= un_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_aryth_op_sequencer.sv
// tb_aryth_op_sequencer: directed and randomized checks against a transaction-level model
module tb_aryth_op_sequencer;
  localparam int T = 32;
  logic clk = 0, rst = 1, ena = 1, in_stb = 0, alu_done = 0, out_ack = 0;
  logic [7:0] in_data = 0;
  logic [15:0] alu_result = 0;
  logic in_rdy, alu_start, out_valid, busy;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, out_data;
  logic [1:0] err;
  int checks = 0, errors = 0, cyc = 0, starts = 0, st_cyc = 0, vcnt = 0, acc_cyc = 0;
  int dly = 4, ack_mode = 1;
  bit noise = 0, ena_rand = 0;
  logic [2:0] st_op;
  logic [7:0] st_a, st_b;
  logic [7:0] rx[$];
  bit m_coll = 1, m_issue = 0, m_wait = 0;
  int m_got = 0, m_need = 0, m_el = 0;
  logic [7:0] m_oq[$];
  logic [1:0] m_err = 0;
  logic [2:0] m_op = 0;
  logic [7:0] m_a = 0, m_b = 0;

  aryth_op_sequencer #(.DATA_W(8), .RES_W(16), .TIMEOUT(T), .NUM_OPS(6)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_data(in_data), .in_stb(in_stb), .in_rdy(in_rdy),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .out_data(out_data), .out_valid(out_valid),
    .out_ack(out_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask

  task automatic fail(input string n);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not happen", n);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_data = b;
    in_stb = 1;
    for (int i = 0; i < 300; i++) begin
      bit ok;
      #2;
      ok = in_rdy && ena && !rst;
      acc_cyc = cyc;
      step(1);
      if (ok) begin
        in_stb = 0;
        return;
      end
    end
    in_stb = 0;
    fail("send");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (!busy) return;
    end
    fail("wait_idle");
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (out_valid) return;
    end
    fail("wait_valid");
  endtask

  task automatic wait_tmo(output int c);
    c = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (err == 2'b10) begin
        c = cyc;
        return;
      end
    end
    fail("wait_tmo");
  endtask

  task automatic chk_rx(input string n, input int k, input logic [7:0] lo, input logic [7:0] hi);
    if (rx.size() < k + 2) fail({n, "_bytes"});
    else begin
      chk({n, "_lo"}, rx[k], lo);
      chk({n, "_hi"}, rx[k+1], hi);
    end
  endtask

  task automatic chk_reset_vals(input string n);
    chk({n, "_in_rdy"}, in_rdy, 1);
    chk({n, "_alu_start"}, alu_start, 0);
    chk({n, "_alu_op"}, alu_op, 0);
    chk({n, "_alu_a"}, alu_a, 0);
    chk({n, "_alu_b"}, alu_b, 0);
    chk({n, "_out_data"}, out_data, 0);
    chk({n, "_out_valid"}, out_valid, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_err"}, err, 0);
  endtask

  task automatic do_rst(input string n);
    rst = 1;
    #1;
    chk_reset_vals(n);
    step(1);
    rst = 0;
  endtask

  // reference model: operand collection, start, bounded wait, two-byte result queue
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_coll = 1; m_issue = 0; m_wait = 0; m_got = 0; m_oq.delete();
      m_err = 0; m_op = 0; m_a = 0; m_b = 0;
    end else if (ena) begin
      if (m_coll) begin
        if (in_stb) begin
          if (m_got == 0) begin
            m_err = 0;
            if (in_data[2:0] < 6) begin
              m_op = in_data[2:0];
              m_need = in_data[7] ? 2 : 3;
              m_got = 1;
            end else m_err = 1;
          end else begin
            if (m_got == 1) begin
              m_a = in_data;
              if (m_need == 2) m_b = 0;
            end else m_b = in_data;
            m_got++;
            if (m_got == m_need) begin
              m_coll = 0; m_got = 0; m_issue = 1;
            end
          end
        end
      end else if (m_issue) begin
        m_issue = 0; m_wait = 1; m_el = 1;
      end else if (m_wait) begin
        if (alu_done) begin
          m_oq = {alu_result[7:0], alu_result[15:8]};
          m_wait = 0;
        end else if (m_el == T - 1) begin
          m_err = 2; m_wait = 0; m_coll = 1;
        end else m_el++;
      end else if (out_ack) begin
        void'(m_oq.pop_front());
        if (m_oq.size() == 0) m_coll = 1;
      end
    end
  end

  // compare process and event monitors, mid-cycle
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("in_rdy", in_rdy, m_coll);
      chk("alu_start", alu_start, m_issue & ena);
      chk("busy", busy, !(m_coll && m_got == 0));
      chk("out_valid", out_valid, m_oq.size() != 0);
      chk("out_data", out_data, m_oq.size() != 0 ? m_oq[0] : 8'h00);
      chk("err", err, m_err);
      if (m_issue || m_wait) begin
        chk("alu_op", alu_op, m_op);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
      end
      if (alu_start) begin
        starts++; st_cyc = cyc; st_op = alu_op; st_a = alu_a; st_b = alu_b;
      end
      if (out_valid) vcnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (ena_rand) ena = ($urandom % 8) != 0;
  end

  // result consumer
  initial forever begin
    @(negedge clk);
    #2;
    out_ack = ack_mode == 1 ? 1'b1 : ack_mode == 2 ? 1'($urandom % 2) : 1'b0;
    if (!rst && out_valid && out_ack && ena) rx.push_back(out_data);
  end

  // datapath stand-in: done dly cycles after start (dly=0 never), optional stray done pulses
  initial begin
    bit pend = 0;
    int left = 0;
    forever begin
      @(negedge clk);
      #2;
      alu_done = 0;
      alu_result = 16'($urandom);
      if (rst) pend = 0;
      else if (alu_start) begin
        pend = dly > 0;
        left = dly;
      end else if (pend) begin
        left--;
        if (left == 0) begin
          alu_done = 1;
          pend = 0;
          alu_result = alu_op == 3'd2 ? 16'(alu_a) * 16'(alu_b) : {alu_a ^ 8'h5A, alu_b + 8'(alu_op)};
        end
      end else if (noise) alu_done = ($urandom % 4) == 0;
    end
  end

  initial begin
    int s0, n, v0, ec;
    logic [7:0] d0, cmd;
    step(3);
    chk_reset_vals("reset");
    rst = 0;
    step(1);
    s0 = starts; n = rx.size(); dly = 4;
    send(8'h02); send(8'h0C); send(8'h05);
    chk("t1_start_lat", st_cyc - acc_cyc, 1);
    wait_idle();
    chk("t1_starts", starts - s0, 1);
    chk("t1_op", st_op, 2);
    chk("t1_a", st_a, 8'h0C);
    chk("t1_b", st_b, 8'h05);
    chk_rx("t1_res", n, 8'h3C, 8'h00);
    s0 = starts; n = rx.size();
    send(8'h81); send(8'hFF);
    chk("t2_start_lat", st_cyc - acc_cyc, 1);
    wait_idle();
    chk("t2_starts", starts - s0, 1);
    chk("t2_op", st_op, 1);
    chk("t2_a", st_a, 8'hFF);
    chk("t2_b", st_b, 8'h00);
    chk_rx("t2_res", n, 8'h01, 8'hA5);
    s0 = starts; n = rx.size();
    send(8'h07);
    step(2);
    chk("t3_err_illop", err, 2'b01);
    chk("t3_busy", busy, 0);
    chk("t3_no_start", starts - s0, 0);
    send(8'h00);
    chk("t3_err_clear", err, 2'b00);
    send(8'h01); send(8'h01);
    wait_idle();
    chk("t3_starts", starts - s0, 1);
    chk_rx("t3_res", n, 8'h01, 8'h5B);
    dly = 0; v0 = vcnt;
    send(8'h03); send(8'h11); send(8'h22);
    wait_tmo(ec);
    chk("t4_tmo_cycles", ec - st_cyc, T);
    chk("t4_busy", busy, 0);
    chk("t4_no_valid", vcnt - v0, 0);
    dly = T - 1; n = rx.size();
    send(8'h04); send(8'h10); send(8'h20);
    wait_idle();
    chk("t4_edge_err", err, 2'b00);
    chk_rx("t4_edge_res", n, 8'h24, 8'h4A);
    dly = T; v0 = vcnt;
    send(8'h04); send(8'h10); send(8'h20);
    wait_idle();
    chk("t4_late_err", err, 2'b10);
    chk("t4_late_no_valid", vcnt - v0, 0);
    ack_mode = 0; dly = 12; n = rx.size();
    send(8'h02); send(8'h03); send(8'h04);
    step(2); ena = 0; step(5); ena = 1;
    wait_valid();
    d0 = out_data;
    chk("t5_lo_byte", d0, 8'h0C);
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_data", out_data, d0);
      step(1);
    end
    ack_mode = 1;
    wait_idle();
    chk_rx("t5_res", n, 8'h0C, 8'h00);
    dly = 0;
    send(8'h03); send(8'h05); send(8'h06);
    step(3); ena = 0; step(5); ena = 1;
    wait_tmo(ec);
    chk("t5_frozen_tmo", ec - st_cyc, T + 5);
    dly = 0;
    send(8'h01); send(8'h07); send(8'h08);
    step(3);
    do_rst("t6_wait_rst");
    ack_mode = 0; dly = 2;
    send(8'h02); send(8'h02); send(8'h02);
    wait_valid();
    ack_mode = 1;
    step(1);
    ack_mode = 0;
    chk("t6_in_hi", out_valid, 1);
    do_rst("t6_hi_rst");
    ack_mode = 1; dly = 4; n = rx.size();
    send(8'h02); send(8'h0C); send(8'h05);
    wait_idle();
    chk_rx("t6_after", n, 8'h3C, 8'h00);
    ena_rand = 1; noise = 1; ack_mode = 2;
    for (int i = 0; i < 250; i++) begin
      cmd = 8'($urandom);
      dly = ($urandom % 6 == 0) ? 0 : int'($urandom_range(1, T + 2));
      send(cmd);
      if (cmd[2:0] < 6) begin
        send(8'($urandom));
        if (!cmd[7]) send(8'($urandom));
      end
    end
    ena_rand = 0; ena = 1; noise = 0; ack_mode = 1;
    wait_idle();
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
